// File: rtl/if_pkg.sv
// Shared constants and the IF/ID bundle type for the instruction fetch stage.
package if_pkg;

   localparam int IF_ADDR_W       = 7;
   localparam int IF_DATA_W       = 32;
   localparam int IF_RESET_PC     = 0;
   localparam int IF_FETCH_CNT_W  = 32;
   localparam int IF_SQUASH_CNT_W = 16;

   // Registered hand-off from fetch to decode.
   typedef struct packed {
      logic [IF_DATA_W-1:0] inst;
      logic [IF_ADDR_W-1:0] pc;
      logic                 valid;
   } if_id_bundle_t;

endpackage : if_pkg

// File: rtl/if_perf_counters.sv
// Saturating fetch/squash event counters for the fetch stage.
// Compiled only when IF_PERF_CNT_EN is defined.
`ifdef IF_PERF_CNT_EN
module if_perf_counters
   import if_pkg::*;
(
   input  logic                       clka,
   input  logic                       rsta,
   input  logic                       fetch_inc,
   input  logic                       squash_inc,
   output logic [IF_FETCH_CNT_W-1:0]  fetch_cnt_o,
   output logic [IF_SQUASH_CNT_W-1:0] squash_cnt_o
);

   always_ff @(posedge clka or posedge rsta) begin
      if (rsta) begin
         fetch_cnt_o  <= '0;
         squash_cnt_o <= '0;
      end else begin
         // Counters stick at all-ones rather than wrapping.
         if (fetch_inc && (fetch_cnt_o != '1))
            fetch_cnt_o <= fetch_cnt_o + IF_FETCH_CNT_W'(1);
         if (squash_inc && (squash_cnt_o != '1))
            squash_cnt_o <= squash_cnt_o + IF_SQUASH_CNT_W'(1);
      end
   end

endmodule : if_perf_counters
`endif

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, drives the sync-read BRAM address and registers the IF/ID bundle.
// Defining IF_PERF_CNT_EN adds fetch_cnt_o / squash_cnt_o performance counters.
module instr_fetch_unit
   import if_pkg::*;
#(
   parameter int ADDR_W   = IF_ADDR_W,
   parameter int DATA_W   = IF_DATA_W,
   parameter int RESET_PC = IF_RESET_PC
) (
   input  logic              clka,
   input  logic              rsta,
   input  logic              stall_i,
   input  logic              redirect_valid_i,
   input  logic [ADDR_W-1:0] redirect_pc_i,
   output logic [ADDR_W-1:0] addra,
   input  logic [DATA_W-1:0] douta,
   output logic [DATA_W-1:0] inst_o,
   output logic [ADDR_W-1:0] pc_o,
   output logic              inst_valid_o
`ifdef IF_PERF_CNT_EN
   ,
   output logic [IF_FETCH_CNT_W-1:0]  fetch_cnt_o,
   output logic [IF_SQUASH_CNT_W-1:0] squash_cnt_o
`endif
);

   localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);

   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pend_pc;
   logic              pend_valid;

   // While stalled the BRAM re-reads pend_pc, keeping douta aligned without a skid buffer.
   assign addra = stall_i ? pend_pc : pc_q;

   // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clka or posedge rsta) begin
      if (rsta) begin
         pc_q         <= RST_PC;
         pend_pc      <= RST_PC;
         pend_valid   <= 1'b0;
         inst_o       <= '0;
         pc_o         <= '0;
         inst_valid_o <= 1'b0;
      end else if (redirect_valid_i) begin
         // Squash both the in-flight read and the registered bundle; inst_o/pc_o just hold.
         pc_q         <= redirect_pc_i;
         pend_valid   <= 1'b0;
         inst_valid_o <= 1'b0;
      end else if (!stall_i) begin
         inst_o       <= douta;
         pc_o         <= pend_pc;
         inst_valid_o <= pend_valid;
         pend_pc      <= pc_q;
         pend_valid   <= 1'b1;
         pc_q         <= pc_q + ADDR_W'(1);
      end
   end

`ifdef IF_PERF_CNT_EN
   if_perf_counters u_perf (
      .clka         (clka),
      .rsta         (rsta),
      .fetch_inc    (!redirect_valid_i && !stall_i && pend_valid),
      .squash_inc   (redirect_valid_i && (pend_valid || inst_valid_o)),
      .fetch_cnt_o  (fetch_cnt_o),
      .squash_cnt_o (squash_cnt_o)
   );
`endif

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus random stall/redirect traffic
// compared against a queue-based fetch-stream model.
module tb_instr_fetch_unit;

   localparam int AW    = 7;
   localparam int DW    = 32;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rsta;
   logic          stall;
   logic          redir;
   logic [AW-1:0] redir_pc;
   logic [AW-1:0] addra;
   logic [DW-1:0] douta;
   logic [DW-1:0] inst;
   logic [AW-1:0] pc;
   logic          valid;

   // Free-running second instance starting at 0x7E to observe address wrap.
   logic [AW-1:0] addra_w;
   logic [DW-1:0] douta_w;
   logic [DW-1:0] inst_w;
   logic [AW-1:0] pc_w;
   logic          valid_w;

`ifdef IF_PERF_CNT_EN
   logic [31:0] fetch_cnt, fetch_cnt_w;
   logic [15:0] squash_cnt, squash_cnt_w;
`endif

   logic [DW-1:0] mem [DEPTH];

   int n_checks = 0;
   int n_bad    = 0;

   always #5 clk = ~clk;

   instr_fetch_unit dut (
      .clka             (clk),
      .rsta             (rsta),
      .stall_i          (stall),
      .redirect_valid_i (redir),
      .redirect_pc_i    (redir_pc),
      .addra            (addra),
      .douta            (douta),
      .inst_o           (inst),
      .pc_o             (pc),
      .inst_valid_o     (valid)
`ifdef IF_PERF_CNT_EN
      ,
      .fetch_cnt_o      (fetch_cnt),
      .squash_cnt_o     (squash_cnt)
`endif
   );

   instr_fetch_unit #(.RESET_PC('h7E)) dut_w (
      .clka             (clk),
      .rsta             (rsta),
      .stall_i          (1'b0),
      .redirect_valid_i (1'b0),
      .redirect_pc_i    ('0),
      .addra            (addra_w),
      .douta            (douta_w),
      .inst_o           (inst_w),
      .pc_o             (pc_w),
      .inst_valid_o     (valid_w)
`ifdef IF_PERF_CNT_EN
      ,
      .fetch_cnt_o      (fetch_cnt_w),
      .squash_cnt_o     (squash_cnt_w)
`endif
   );

   // Synchronous-read BRAMs, one cycle latency, no enable.
   always @(posedge clk) begin
      douta   <= mem[addra];
      douta_w <= mem[addra_w];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model: stream of issued addresses ----------------
   int unsigned inflight[$];   // addresses whose data is on its way back
   int unsigned nxt;           // next address to issue
   bit          m_valid;
   int unsigned m_pc;
   int unsigned m_fetch;
   int unsigned m_squash;

   function automatic void model_reset();
      inflight.delete();
      nxt      = 0;
      m_valid  = 1'b0;
      m_pc     = 0;
      m_fetch  = 0;
      m_squash = 0;
   endfunction

   function automatic void model_edge(input bit st, input bit rd, input int unsigned tgt);
      if (rd) begin
         if ((inflight.size() != 0) || m_valid)
            if (m_squash < 16'hFFFF) m_squash++;
         inflight.delete();
         nxt     = tgt;
         m_valid = 1'b0;
      end else if (!st) begin
         if (inflight.size() != 0) begin
            m_pc    = inflight.pop_front();
            m_valid = 1'b1;
            m_fetch++;
         end else begin
            m_valid = 1'b0;
         end
         inflight.push_back(nxt);
         nxt = (nxt + 1) % DEPTH;
      end
   endfunction

   task automatic check_outputs();
      check("valid", 32'(valid), 32'(m_valid));
      if (m_valid) begin
         check("pc", 32'(pc), m_pc);
         check("inst", inst, m_pc + 32'h100);
      end
      if (!stall)
         check("addra", 32'(addra), nxt);
      else if (inflight.size() != 0)
         check("addra_stall", 32'(addra), inflight[0]);
`ifdef IF_PERF_CNT_EN
      check("fetch_cnt", fetch_cnt, m_fetch);
      check("squash_cnt", 32'(squash_cnt), m_squash);
`endif
   endtask

   // Entered at a falling edge: drive, check, let one rising edge happen, return at next falling edge.
   task automatic step(input bit st, input bit rd, input int unsigned tgt);
      stall    = st;
      redir    = rd;
      redir_pc = AW'(tgt);
      #1 check_outputs();
      @(posedge clk);
      model_edge(st, rd, tgt);
      @(negedge clk);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_valid"}, 32'(valid), 32'd0);
      check({tag, "_pc"}, 32'(pc), 32'd0);
      check({tag, "_inst"}, inst, 32'd0);
      check({tag, "_addra"}, 32'(addra), 32'd0);
`ifdef IF_PERF_CNT_EN
      check({tag, "_fetch_cnt"}, fetch_cnt, 32'd0);
      check({tag, "_squash_cnt"}, 32'(squash_cnt), 32'd0);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int e;
      for (int i = 0; i < DEPTH; i++) mem[i] = 32'h100 + i;
      rsta     = 1'b1;
      stall    = 1'b0;
      redir    = 1'b0;
      redir_pc = '0;
      model_reset();
      repeat (2) @(negedge clk);
      check_reset_state("por");
      rsta = 1'b0;

      // Startup, then free run to pc 5; wrap instance checked alongside.
      e = 0;
      while (!(m_valid && m_pc == 5) && e < 20) begin
         step(1'b0, 1'b0, 0);
         e++;
         if (e >= 2 && e <= 5) begin
            check("wrap_valid", 32'(valid_w), 32'd1);
            check("wrap_pc", 32'(pc_w), (32'h7E + e - 2) % DEPTH);
            check("wrap_inst", inst_w, 32'h100 + (32'h7E + e - 2) % DEPTH);
         end
      end

      // Three-cycle stall with pc 5 on the outputs, then resume.
      repeat (3) step(1'b1, 1'b0, 0);
      e = 0;
      while (!(m_valid && m_pc == 10) && e < 20) begin
         step(1'b0, 1'b0, 0);
         e++;
      end

      // Redirect to 0x40, then drain.
      step(1'b0, 1'b1, 'h40);
      repeat (3) step(1'b0, 1'b0, 0);

      // Redirect and stall together, stall held one more cycle.
      step(1'b1, 1'b1, 'h20);
      step(1'b1, 1'b0, 0);
      repeat (3) step(1'b0, 1'b0, 0);

      // Redirect near the top of memory to cross the wrap.
      step(1'b0, 1'b1, 'h7E);
      repeat (6) step(1'b0, 1'b0, 0);

      // Asynchronous reset between edges while stalled.
      stall = 1'b1;
      #2 rsta = 1'b1;
      #1 check_reset_state("async_rst");
      model_reset();
      @(negedge clk);
      check_reset_state("rst_hold");
      rsta = 1'b0;
      repeat (4) step(1'b0, 1'b0, 0);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, DEPTH - 1));
      end
      stall = 1'b0;
      redir = 1'b0;
      #1 check_outputs();

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule : tb_instr_fetch_unit
